ex_stage_mdu: RTL and testbench

- Execute stage of the 5-stage MIPS pipeline, directly downstream of the forwarding unit.
- Consumes forwarda/forwardb to select operand sources, runs a single-cycle ALU and an iterative 32-cycle multiply/divide unit (MDU) owning HI/LO.
- Drives the EX/MEM latch inputs and a stall that freezes PC, IF/ID and ID/EX and bubbles EX/MEM while the MDU is busy.

---
 rtl/ex_stage_mdu_pkg.sv | 62 ++++++
 rtl/ex_stage_mdu_if.sv | 45 ++++
 rtl/ex_stage_mdu_iter.sv | 169 ++++++++++++++++
 rtl/ex_stage_mdu.sv | 69 ++++++
 tb/tb_ex_stage_mdu.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/ex_stage_mdu_pkg.sv
// ex_stage_mdu_pkg
// Shared definitions for the MIPS execute stage and its multiply/divide unit:
// datapath width, ALU and MDU operation encodings, forwarding select codes,
// MDU FSM states and the operand forwarding mux helper.
package ex_stage_mdu_pkg;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 5;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_NOR  = 4'd5,
    ALU_SLT  = 4'd6,
    ALU_SLTU = 4'd7,
    ALU_SLL  = 4'd8,
    ALU_SRL  = 4'd9,
    ALU_SRA  = 4'd10,
    ALU_LUI  = 4'd11,
    ALU_MFHI = 4'd12,
    ALU_MFLO = 4'd13
  } alu_op_e;

  typedef enum logic [2:0] {
    MDU_NONE  = 3'd0,
    MDU_MULT  = 3'd1,
    MDU_MULTU = 3'd2,
    MDU_DIV   = 3'd3,
    MDU_DIVU  = 3'd4,
    MDU_MTHI  = 3'd5,
    MDU_MTLO  = 3'd6
  } mdu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } mdu_state_e;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;

  // Select code 11 is unused by the forwarding unit and falls back to the regfile.
  function automatic logic [DATA_W-1:0] fwd_select(
    input logic [1:0]        sel,
    input logic [DATA_W-1:0] rf_data,
    input logic [DATA_W-1:0] exmem_data,
    input logic [DATA_W-1:0] memwb_data
  );
    case (sel)
      FWD_EXMEM: return exmem_data;
      FWD_MEMWB: return memwb_data;
      default:   return rf_data;
    endcase
  endfunction

endpackage

// File: rtl/ex_stage_mdu_if.sv
// ex_stage_mdu_if
// Bundle of the ID/EX-side inputs and the EX/MEM-side outputs of the execute
// stage. The master modport belongs to the surrounding pipeline, the slave
// modport to ex_stage_mdu.
//   inputs to EX : ex_valid, ex_flush, forwarda/b, idex_* operands, forwarded
//                  EX/MEM and MEM/WB data, alusrc, alu_op, mdu_op
//   outputs of EX: ex_result, ex_store_data, ex_stall, mdu_busy, hi_out, lo_out
interface ex_stage_mdu_if;
  import ex_stage_mdu_pkg::*;

  logic              ex_valid;
  logic              ex_flush;
  logic [1:0]        forwarda;
  logic [1:0]        forwardb;
  logic [DATA_W-1:0] idex_rs_data;
  logic [DATA_W-1:0] idex_rt_data;
  logic [DATA_W-1:0] exmem_fwd_data;
  logic [DATA_W-1:0] memwb_fwd_data;
  logic [DATA_W-1:0] idex_imm;
  logic [4:0]        idex_shamt;
  logic              alusrc;
  logic [3:0]        alu_op;
  logic [2:0]        mdu_op;
  logic [DATA_W-1:0] ex_result;
  logic [DATA_W-1:0] ex_store_data;
  logic              ex_stall;
  logic              mdu_busy;
  logic [DATA_W-1:0] hi_out;
  logic [DATA_W-1:0] lo_out;

  modport master (
    output ex_valid, ex_flush, forwarda, forwardb, idex_rs_data, idex_rt_data,
           exmem_fwd_data, memwb_fwd_data, idex_imm, idex_shamt, alusrc,
           alu_op, mdu_op,
    input  ex_result, ex_store_data, ex_stall, mdu_busy, hi_out, lo_out
  );

  modport slave (
    input  ex_valid, ex_flush, forwarda, forwardb, idex_rs_data, idex_rt_data,
           exmem_fwd_data, memwb_fwd_data, idex_imm, idex_shamt, alusrc,
           alu_op, mdu_op,
    output ex_result, ex_store_data, ex_stall, mdu_busy, hi_out, lo_out
  );

endinterface

// File: rtl/ex_stage_mdu_iter.sv
// ex_stage_mdu_iter
// Iterative multiply/divide unit owning HI/LO. Signed operations are done on
// magnitudes with the signs reapplied in the FIX state; one shift-add or
// restoring-subtract step is performed per BUSY cycle.
//   clk, rst_n        : clock, asynchronous active-low reset
//   ex_valid/ex_flush : instruction qualifier and squash from the pipeline
//   mdu_op            : requested MDU operation
//   op_a, op_b        : forwarded rs / rt operands
//   hi, lo            : architectural HI/LO registers
//   stall             : freeze upstream while a multi-cycle op is in flight
//   busy              : FSM is in BUSY or FIX
module ex_stage_mdu_iter
  import ex_stage_mdu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  input  logic              ex_flush,
  input  logic [2:0]        mdu_op,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo,
  output logic              stall,
  output logic              busy
);

  mdu_state_e state, state_next;

  logic [CNT_W-1:0]    cnt;
  logic [DATA_W-1:0]   acc_hi, acc_lo, operand;
  logic                is_div, neg_main, neg_rem;

  logic                req_ok, is_start_op, div_op, signed_op, start, div_zero;
  logic                sign_a, sign_b;
  logic [DATA_W-1:0]   mag_a, mag_b;
  logic [DATA_W:0]     mul_sum, div_shift, div_diff;
  logic [2*DATA_W-1:0] product, prod_fixed;
  logic [DATA_W-1:0]   quot_fixed, rem_fixed;

  assign req_ok      = ex_valid && !ex_flush && (state == ST_IDLE);
  assign div_op      = (mdu_op == MDU_DIV) || (mdu_op == MDU_DIVU);
  assign signed_op   = (mdu_op == MDU_MULT) || (mdu_op == MDU_DIV);
  assign is_start_op = div_op || (mdu_op == MDU_MULT) || (mdu_op == MDU_MULTU);
  assign start       = req_ok && is_start_op;
  assign div_zero    = div_op && (op_b == '0);

  assign sign_a = signed_op && op_a[DATA_W-1];
  assign sign_b = signed_op && op_b[DATA_W-1];
  assign mag_a  = sign_a ? -op_a : op_a;
  assign mag_b  = sign_b ? -op_b : op_b;

  // Multiply: acc_lo holds the multiplier and shifts right while the product
  // grows into acc_hi. Divide: acc_lo holds the dividend shifting out the top
  // and the quotient bits shifting in at the bottom; acc_hi is the remainder.
  assign mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, operand} : '0);
  assign div_shift = {acc_hi, acc_lo[DATA_W-1]};
  assign div_diff  = div_shift - {1'b0, operand};

  assign product    = {acc_hi, acc_lo};
  assign prod_fixed = neg_main ? -product : product;
  assign quot_fixed = neg_main ? -acc_lo : acc_lo;
  assign rem_fixed  = neg_rem ? -acc_hi : acc_hi;

  assign busy = (state == ST_BUSY) || (state == ST_FIX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  // A flush during BUSY/FIX drops the stall immediately so the squashed
  // instruction is not held while the FSM falls back to IDLE.
  always_comb begin
    state_next = state;
    stall      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          stall      = 1'b1;
          state_next = div_zero ? ST_DONE : ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (ex_flush) begin
          state_next = ST_IDLE;
        end else begin
          stall = 1'b1;
          if (cnt == CNT_W'(DATA_W - 1)) state_next = ST_FIX;
        end
      end
      ST_FIX: begin
        if (ex_flush) begin
          state_next = ST_IDLE;
        end else begin
          stall      = 1'b1;
          state_next = ST_DONE;
        end
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      operand  <= '0;
      is_div   <= 1'b0;
      neg_main <= 1'b0;
      neg_rem  <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            cnt      <= '0;
            is_div   <= div_op;
            neg_main <= sign_a ^ sign_b;
            neg_rem  <= sign_a;
            acc_hi   <= '0;
            acc_lo   <= div_op ? mag_a : mag_b;
            operand  <= div_op ? mag_b : mag_a;
            if (div_zero) begin
              hi <= op_a;
              lo <= '1;
            end
          end else if (req_ok && (mdu_op == MDU_MTHI)) begin
            hi <= op_a;
          end else if (req_ok && (mdu_op == MDU_MTLO)) begin
            lo <= op_a;
          end
        end
        ST_BUSY: begin
          if (!ex_flush) begin
            cnt <= cnt + CNT_W'(1);
            if (is_div) begin
              if (!div_diff[DATA_W]) begin
                acc_hi <= div_diff[DATA_W-1:0];
                acc_lo <= {acc_lo[DATA_W-2:0], 1'b1};
              end else begin
                acc_hi <= div_shift[DATA_W-1:0];
                acc_lo <= {acc_lo[DATA_W-2:0], 1'b0};
              end
            end else begin
              {acc_hi, acc_lo} <= {mul_sum, acc_lo[DATA_W-1:1]};
            end
          end
        end
        ST_FIX: begin
          if (!ex_flush) begin
            if (is_div) begin
              hi <= rem_fixed;
              lo <= quot_fixed;
            end else begin
              hi <= prod_fixed[2*DATA_W-1:DATA_W];
              lo <= prod_fixed[DATA_W-1:0];
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/ex_stage_mdu.sv
// ex_stage_mdu
// Execute stage of the 5-stage MIPS pipeline: operand forwarding muxes, the
// single-cycle ALU, the EX result mux and the iterative MDU holding HI/LO.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of ex_stage_mdu_if (ID/EX inputs, EX/MEM outputs,
//                stall, MDU status and HI/LO)
module ex_stage_mdu
  import ex_stage_mdu_pkg::*;
(
  input logic           clk,
  input logic           rst_n,
  ex_stage_mdu_if.slave bus
);

  logic [DATA_W-1:0] op_a, fwd_b, op_b, alu_res;
  logic [DATA_W-1:0] hi, lo;
  logic              stall, busy;

  always_comb begin
    op_a  = fwd_select(bus.forwarda, bus.idex_rs_data, bus.exmem_fwd_data, bus.memwb_fwd_data);
    fwd_b = fwd_select(bus.forwardb, bus.idex_rt_data, bus.exmem_fwd_data, bus.memwb_fwd_data);
    op_b  = bus.alusrc ? bus.idex_imm : fwd_b;
  end

  // Shifts operate on operand B by the instruction's shamt field, as MIPS
  // SLL/SRL/SRA shift rt.
  always_comb begin
    alu_res = '0;
    case (bus.alu_op)
      ALU_ADD:  alu_res = op_a + op_b;
      ALU_SUB:  alu_res = op_a - op_b;
      ALU_AND:  alu_res = op_a & op_b;
      ALU_OR:   alu_res = op_a | op_b;
      ALU_XOR:  alu_res = op_a ^ op_b;
      ALU_NOR:  alu_res = ~(op_a | op_b);
      ALU_SLT:  alu_res = {{(DATA_W-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      ALU_SLTU: alu_res = {{(DATA_W-1){1'b0}}, (op_a < op_b)};
      ALU_SLL:  alu_res = op_b << bus.idex_shamt;
      ALU_SRL:  alu_res = op_b >> bus.idex_shamt;
      ALU_SRA:  alu_res = $signed(op_b) >>> bus.idex_shamt;
      ALU_LUI:  alu_res = bus.idex_imm << 16;
      ALU_MFHI: alu_res = hi;
      ALU_MFLO: alu_res = lo;
      default:  alu_res = '0;
    endcase
  end

  ex_stage_mdu_iter u_mdu (
    .clk      (clk),
    .rst_n    (rst_n),
    .ex_valid (bus.ex_valid),
    .ex_flush (bus.ex_flush),
    .mdu_op   (bus.mdu_op),
    .op_a     (op_a),
    .op_b     (fwd_b),
    .hi       (hi),
    .lo       (lo),
    .stall    (stall),
    .busy     (busy)
  );

  assign bus.ex_result     = alu_res;
  assign bus.ex_store_data = fwd_b;
  assign bus.ex_stall      = stall;
  assign bus.mdu_busy      = busy;
  assign bus.hi_out        = hi;
  assign bus.lo_out        = lo;

endmodule

// File: tb/tb_ex_stage_mdu.sv
// tb_ex_stage_mdu
// Self-checking bench for ex_stage_mdu. Inputs are driven on the falling edge
// and outputs sampled 1 time unit later; expected values come from plain
// arithmetic models of the ALU, the forwarding selects and HI/LO.
module tb_ex_stage_mdu;
  import ex_stage_mdu_pkg::*;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  ex_stage_mdu_if bus ();

  ex_stage_mdu dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [31:0] model_hi = 32'h0;
  logic [31:0] model_lo = 32'h0;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [31:0] model_fwd(input logic [1:0] sel, input logic [31:0] rf,
                                            input logic [31:0] exmem, input logic [31:0] memwb);
    if (sel == 2'd1) return exmem;
    if (sel == 2'd2) return memwb;
    return rf;
  endfunction

  function automatic logic [31:0] model_alu(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input logic [31:0] imm,
                                            input logic [4:0] sh);
    int signed sa;
    int signed sb;
    sa = a;
    sb = b;
    case (op)
      ALU_ADD:  return a + b;
      ALU_SUB:  return a - b;
      ALU_AND:  return a & b;
      ALU_OR:   return a | b;
      ALU_XOR:  return a ^ b;
      ALU_NOR:  return ~(a | b);
      ALU_SLT:  return (sa < sb) ? 32'd1 : 32'd0;
      ALU_SLTU: return (a < b) ? 32'd1 : 32'd0;
      ALU_SLL:  return b << sh;
      ALU_SRL:  return b >> sh;
      ALU_SRA:  return sb >>> sh;
      ALU_LUI:  return {imm[15:0], 16'h0};
      ALU_MFHI: return model_hi;
      ALU_MFLO: return model_lo;
      default:  return 32'h0;
    endcase
  endfunction

  // Returns {HI, LO} from whole-number arithmetic on 64-bit values.
  function automatic logic [63:0] model_mdu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] ua, ub, uq, ur;
    sa = $signed(a);
    sb = $signed(b);
    ua = {32'h0, a};
    ub = {32'h0, b};
    case (op)
      MDU_MULT:  begin q = sa * sb; return q; end
      MDU_MULTU: return ua * ub;
      MDU_DIV: begin
        if (b == 32'h0) return {a, 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      MDU_DIVU: begin
        if (b == 32'h0) return {a, 32'hFFFF_FFFF};
        uq = ua / ub;
        ur = ua % ub;
        return {ur[31:0], uq[31:0]};
      end
      default: return {model_hi, model_lo};
    endcase
  endfunction

  task automatic applyStimulus(input logic valid, input logic [2:0] mop, input logic [3:0] aop,
                               input logic [1:0] fa, input logic [1:0] fb, input logic src,
                               input logic [31:0] rs, input logic [31:0] rt, input logic [31:0] exm,
                               input logic [31:0] mwb, input logic [31:0] imm, input logic [4:0] sh);
    bus.ex_valid       = valid;
    bus.ex_flush       = 1'b0;
    bus.mdu_op         = mop;
    bus.alu_op         = aop;
    bus.forwarda       = fa;
    bus.forwardb       = fb;
    bus.alusrc         = src;
    bus.idex_rs_data   = rs;
    bus.exmem_fwd_data = exm;
    bus.memwb_fwd_data = mwb;
    bus.idex_rt_data   = rt;
    bus.idex_imm       = imm;
    bus.idex_shamt     = sh;
  endtask

  task automatic checkAlu(input string tag, input logic [3:0] aop, input logic [1:0] fa,
                          input logic [1:0] fb, input logic src, input logic [31:0] rs,
                          input logic [31:0] rt, input logic [31:0] exm, input logic [31:0] mwb,
                          input logic [31:0] imm, input logic [4:0] sh);
    logic [31:0] a, b_fwd, b;
    @(negedge clk);
    applyStimulus(1'b1, MDU_NONE, aop, fa, fb, src, rs, rt, exm, mwb, imm, sh);
    #1;
    a     = model_fwd(fa, rs, exm, mwb);
    b_fwd = model_fwd(fb, rt, exm, mwb);
    b     = src ? imm : b_fwd;
    checkOutput({tag, " result"}, bus.ex_result, model_alu(aop, a, b, imm, sh));
    checkOutput({tag, " store"}, bus.ex_store_data, b_fwd);
    checkOutput({tag, " stall"}, {31'h0, bus.ex_stall}, 32'h0);
  endtask

  task automatic runMdu(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int stall_cycles;
    logic [63:0] exp;
    exp = model_mdu(op, a, b);
    @(negedge clk);
    applyStimulus(1'b1, op, ALU_MFHI, 2'd0, 2'd0, 1'b0, a, b, 32'h0, 32'h0, 32'h0, 5'd0);
    #1;
    stall_cycles = 0;
    while (bus.ex_stall === 1'b1 && stall_cycles < 100) begin
      stall_cycles++;
      @(negedge clk);
      #1;
    end
    model_hi = exp[63:32];
    model_lo = exp[31:0];
    checkOutput({tag, " stall cycles"}, stall_cycles,
                ((op == MDU_DIV || op == MDU_DIVU) && b == 32'h0) ? 32'd1 : 32'd34);
    checkOutput({tag, " busy in done"}, {31'h0, bus.mdu_busy}, 32'h0);
    checkOutput({tag, " hi"}, bus.hi_out, model_hi);
    checkOutput({tag, " lo"}, bus.lo_out, model_lo);
    checkOutput({tag, " mfhi"}, bus.ex_result, model_hi);
    bus.ex_valid = 1'b0;
    bus.mdu_op   = MDU_NONE;
    @(negedge clk);
    #1;
    checkOutput({tag, " idle stall"}, {31'h0, bus.ex_stall}, 32'h0);
  endtask

  task automatic runMove(input string tag, input logic [2:0] op, input logic [31:0] val);
    @(negedge clk);
    applyStimulus(1'b1, op, ALU_ADD, 2'd0, 2'd0, 1'b0, val, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0);
    #1;
    checkOutput({tag, " stall"}, {31'h0, bus.ex_stall}, 32'h0);
    if (op == MDU_MTHI) model_hi = val;
    else                model_lo = val;
    @(negedge clk);
    applyStimulus(1'b0, MDU_NONE, (op == MDU_MTHI) ? ALU_MFHI : ALU_MFLO, 2'd0, 2'd0, 1'b0,
                  32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0);
    #1;
    checkOutput({tag, " readback"}, bus.ex_result, val);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic [2:0]  rop;
    logic [31:0] ra, rb;
    rst_n = 1'b0;
    applyStimulus(1'b0, MDU_NONE, ALU_ADD, 2'd0, 2'd0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0);
    repeat (2) @(negedge clk);
    #1;
    checkOutput("reset stall", {31'h0, bus.ex_stall}, 32'h0);
    checkOutput("reset busy", {31'h0, bus.mdu_busy}, 32'h0);
    checkOutput("reset hi", bus.hi_out, 32'h0);
    checkOutput("reset lo", bus.lo_out, 32'h0);
    rst_n = 1'b1;

    checkAlu("fwd exmem add", ALU_ADD, 2'd1, 2'd0, 1'b1, 32'h5, 32'h0, 32'h10, 32'h0, 32'h3, 5'd0);
    checkAlu("fwd 11 add", ALU_ADD, 2'd3, 2'd0, 1'b1, 32'h5, 32'h0, 32'h10, 32'h0, 32'h3, 5'd0);
    checkAlu("fwd memwb sub", ALU_SUB, 2'd2, 2'd1, 1'b0, 32'h5, 32'h7, 32'h10, 32'h40, 32'h3, 5'd0);
    checkAlu("lui", ALU_LUI, 2'd0, 2'd0, 1'b1, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0000_1234, 5'd0);
    checkAlu("sra neg", ALU_SRA, 2'd0, 2'd0, 1'b0, 32'h0, 32'h8000_0000, 32'h0, 32'h0, 32'h0, 5'd31);
    checkAlu("slt neg", ALU_SLT, 2'd0, 2'd0, 1'b0, 32'hFFFF_FFFF, 32'h1, 32'h0, 32'h0, 32'h0, 5'd0);
    checkAlu("sltu neg", ALU_SLTU, 2'd0, 2'd0, 1'b0, 32'hFFFF_FFFF, 32'h1, 32'h0, 32'h0, 32'h0, 5'd0);

    runMdu("mult -3*7", MDU_MULT, 32'hFFFF_FFFD, 32'd7);
    runMdu("divu 100/7", MDU_DIVU, 32'd100, 32'd7);
    runMdu("div -7/2", MDU_DIV, 32'hFFFF_FFF9, 32'd2);
    runMdu("div 5/0", MDU_DIV, 32'd5, 32'd0);
    runMdu("div min/-1", MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    runMdu("multu max", MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

    // Flush a MULTU in its tenth BUSY cycle: HI/LO must keep the moved values.
    runMove("mthi", MDU_MTHI, 32'hAA);
    runMove("mtlo", MDU_MTLO, 32'h55);
    @(negedge clk);
    applyStimulus(1'b1, MDU_MULTU, ALU_MFHI, 2'd0, 2'd0, 1'b0, 32'h1234, 32'h5678,
                  32'h0, 32'h0, 32'h0, 5'd0);
    repeat (11) @(negedge clk);
    #1;
    checkOutput("flush busy before", {31'h0, bus.mdu_busy}, 32'h1);
    bus.ex_flush = 1'b1;
    @(negedge clk);
    bus.ex_flush = 1'b0;
    bus.ex_valid = 1'b0;
    bus.mdu_op   = MDU_NONE;
    #1;
    checkOutput("flush stall after", {31'h0, bus.ex_stall}, 32'h0);
    checkOutput("flush busy after", {31'h0, bus.mdu_busy}, 32'h0);
    checkOutput("flush hi kept", bus.hi_out, 32'hAA);
    checkOutput("flush lo kept", bus.lo_out, 32'h55);
    checkOutput("flush mfhi", bus.ex_result, 32'hAA);

    // Asynchronous reset in the twentieth BUSY cycle.
    @(negedge clk);
    applyStimulus(1'b1, MDU_MULT, ALU_MFLO, 2'd0, 2'd0, 1'b0, 32'h3, 32'h9,
                  32'h0, 32'h0, 32'h0, 5'd0);
    repeat (21) @(negedge clk);
    #1;
    checkOutput("rst busy before", {31'h0, bus.mdu_busy}, 32'h1);
    rst_n        = 1'b0;
    bus.ex_valid = 1'b0;
    bus.mdu_op   = MDU_NONE;
    #1;
    model_hi = 32'h0;
    model_lo = 32'h0;
    checkOutput("rst stall", {31'h0, bus.ex_stall}, 32'h0);
    checkOutput("rst busy", {31'h0, bus.mdu_busy}, 32'h0);
    checkOutput("rst hi", bus.hi_out, 32'h0);
    checkOutput("rst lo", bus.lo_out, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 24; i++) begin
      checkAlu("rand alu", 4'($urandom_range(0, 13)), 2'($urandom_range(0, 3)),
               2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom, $urandom,
               $urandom, $urandom, $urandom, 5'($urandom_range(0, 31)));
    end

    for (int i = 0; i < 14; i++) begin
      rop = 3'($urandom_range(1, 4));
      ra  = $urandom;
      rb  = ($urandom_range(0, 5) == 0) ? 32'h0 : $urandom;
      if ($urandom_range(0, 2) == 0) rb = rb >> $urandom_range(8, 28);
      runMdu("rand mdu", rop, ra, rb);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
